// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared constants for the instruction-fetch stage: the HALT and NOP
// instruction encodings, the byte size of one instruction word and the
// fetch FSM state encodings.
// ---------------------------------------------------------------------------
package if_stage_pkg;

  // Bytes per instruction word; the PC advances by this amount.
  localparam int unsigned WORD_BYTES = 4;

  // Instruction encodings recognised by the fetch stage.
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  // Fetch FSM states, also exposed on the debug readout.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/if_stage_instr_mem.sv
// ---------------------------------------------------------------------------
// instr_mem
// Instruction memory: MEM_DEPTH words of MSB bits, asynchronous read and
// synchronous write. Contents have no reset; they persist across core
// resets so a loaded program survives a restart.
//
// Ports:
//   i_clk    rising-edge clock
//   i_we     write strobe (already qualified by the caller)
//   i_waddr  write word address
//   i_wdata  write data
//   i_raddr  read word address
//   o_rdata  read data (combinational)
// ---------------------------------------------------------------------------
module instr_mem #(
  parameter int MSB       = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [MSB-1:0]    i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [MSB-1:0]    o_rdata
);

  logic [MSB-1:0] mem_q [MEM_DEPTH];

  // Synchronous write port; no reset so contents survive core reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Reads the word addressed by the current PC,
// computes the next PC for program_counter, loads the IF/ID pipeline
// register, hosts the debug program-load path and detects HALT.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_pc                 current PC from program_counter
//   i_start              debug: leave IDLE and begin execution
//   i_step_en            execution enable (1 = run, pulse = single step)
//   i_stall              hazard unit: hold PC and IF/ID
//   i_redirect           taken branch/jump from ID
//   i_redirect_pc        redirect target
//   i_load_we/addr/data  debug instruction-memory write port (IDLE only)
//   o_next_pc            next PC value (combinational)
//   o_write_pc           PC write enable (combinational)
//   o_ifid_instr/pc4     IF/ID register contents
//   o_ifid_valid         IF/ID holds a real instruction
//   o_halt               sticky HALT flag
//   o_state              FSM state readout
// ---------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter int MSB       = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [MSB-1:0]    i_pc,
  input  logic              i_start,
  input  logic              i_step_en,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [MSB-1:0]    i_redirect_pc,
  input  logic              i_load_we,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [MSB-1:0]    i_load_data,
  output logic [MSB-1:0]    o_next_pc,
  output logic              o_write_pc,
  output logic [MSB-1:0]    o_ifid_instr,
  output logic [MSB-1:0]    o_ifid_pc4,
  output logic              o_ifid_valid,
  output logic              o_halt,
  output logic [1:0]        o_state
);

  localparam logic [MSB-1:0] HALT_W = MSB'(HALT_INSTR);
  localparam logic [MSB-1:0] NOP_W  = MSB'(NOP_INSTR);
  localparam logic [MSB-1:0] STEP_W = MSB'(WORD_BYTES);

  state_e         state_q, state_d;
  logic [MSB-1:0] instr_q, instr_d;
  logic [MSB-1:0] pc4_q, pc4_d;
  logic           valid_q, valid_d;
  logic           halt_q, halt_d;

  logic [MSB-1:0] pc4_s;
  logic [MSB-1:0] rdata_s;
  logic [MSB-1:0] fetched_s;
  logic           oor_s;
  logic           is_halt_s;
  logic           mem_we_s;
  logic           advance_s;
  logic           halt_take_s;
  logic [MSB-1:0] next_pc_s;
  logic           write_pc_s;

  // Program loading is only legal while the core is parked in IDLE.
  assign mem_we_s = i_load_we && (state_q == ST_IDLE);

  instr_mem #(
    .MSB       (MSB),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_instr_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we_s),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_raddr (i_pc[ADDR_W+1:2]),
    .o_rdata (rdata_s)
  );

  // Any byte address beyond the array fetches as HALT so a runaway PC stops.
  assign oor_s     = (i_pc[MSB-1:ADDR_W+2] != {(MSB-ADDR_W-2){1'b0}});
  assign fetched_s = oor_s ? HALT_W : rdata_s;
  assign is_halt_s = (fetched_s == HALT_W);
  assign pc4_s     = i_pc + STEP_W;

  // A fetch is consumed only in RUN, enabled, and not redirected or stalled.
  assign advance_s   = (state_q == ST_RUN) && i_step_en && !i_redirect && !i_stall;
  assign halt_take_s = advance_s && is_halt_s;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_take_s) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: next-PC mux, PC write enable and IF/ID next values.
  always_comb begin
    next_pc_s  = pc4_s;
    write_pc_s = 1'b0;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    halt_d     = halt_q;
    case (state_q)
      ST_RUN: begin
        if (!i_step_en) begin
          // Step mode paused: everything holds.
          write_pc_s = 1'b0;
        end else if (i_redirect) begin
          // Redirect outranks stall and flushes the wrong-path fetch.
          next_pc_s  = i_redirect_pc;
          write_pc_s = 1'b1;
          instr_d    = NOP_W;
          pc4_d      = {MSB{1'b0}};
          valid_d    = 1'b0;
        end else if (i_stall) begin
          write_pc_s = 1'b0;
        end else if (is_halt_s) begin
          // PC freezes on the HALT word; HALT itself still enters IF/ID.
          write_pc_s = 1'b0;
          instr_d    = HALT_W;
          pc4_d      = pc4_s;
          valid_d    = 1'b1;
          halt_d     = 1'b1;
        end else begin
          write_pc_s = 1'b1;
          instr_d    = fetched_s;
          pc4_d      = pc4_s;
          valid_d    = 1'b1;
        end
      end
      ST_IDLE, ST_HALTED: begin
        // Bubbles drain the downstream pipeline.
        instr_d = NOP_W;
        pc4_d   = {MSB{1'b0}};
        valid_d = 1'b0;
      end
      default: begin
        instr_d = NOP_W;
        pc4_d   = {MSB{1'b0}};
        valid_d = 1'b0;
      end
    endcase
  end

  // IF/ID pipeline register and sticky HALT flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_q <= {MSB{1'b0}};
      pc4_q   <= {MSB{1'b0}};
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end

  assign o_next_pc    = next_pc_s;
  assign o_write_pc   = write_pc_s && !i_rst;
  assign o_ifid_instr = instr_q;
  assign o_ifid_pc4   = pc4_q;
  assign o_ifid_valid = valid_q;
  assign o_halt       = halt_q;
  assign o_state      = state_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core, sitting directly downstream of `program_counter`. It reads `o_pc`, fetches the addressed word from a local instruction memory and computes the next PC. It drives `next_pc`/`write_pc` back into the PC and loads the IF/ID pipeline register. It also hosts the debug-unit program-load path and detects HALT.

## Interface
Parameters:
- `MSB`, 32, data/PC width
- `MEM_DEPTH`, 256, instruction memory depth in words (power of two)
- `ADDR_W`, 8, log2(`MEM_DEPTH`)

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  rising-edge clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_pc`  in  MSB  current PC (`o_pc` of `program_counter`)
- `i_start`  in  1  debug unit: leave IDLE, begin execution
- `i_step_en`  in  1  execution enable (tie 1 for continuous; pulse for step mode)
- `i_stall`  in  1  hazard unit: hold PC and IF/ID
- `i_redirect`  in  1  taken branch/jump resolved in ID
- `i_redirect_pc`  in  MSB  target of the redirect
- `i_load_we`  in  1  debug unit: instruction-memory write strobe
- `i_load_addr`  in  ADDR_W  word address for load
- `i_load_data`  in  MSB  instruction word to store
- `o_next_pc`  out  MSB  to `program_counter.next_pc` (combinational)
- `o_write_pc`  out  1  to `program_counter.write_pc` (combinational)
- `o_ifid_instr`  out  MSB  IF/ID instruction (registered)
- `o_ifid_pc4`  out  MSB  IF/ID PC+4 (registered)
- `o_ifid_valid`  out  1  IF/ID holds a real instruction
- `o_halt`  out  1  HALT fetched; sticky until reset
- `o_state`  out  2  FSM state for debug readout

## Operation
- FSM states: IDLE=0, RUN=1, HALTED=2.
  - IDLE→RUN on `i_start`.
  - RUN→HALTED when a HALT word is accepted into IF/ID.
  - HALTED→IDLE only by `i_rst`.
- Memory:
  - `MEM_DEPTH`×`MSB` array with asynchronous read at word `i_pc[ADDR_W+1:2]`; `i_pc[1:0]` ignored.
  - Writes are accepted only in IDLE, on the edge with `i_load_we`=1.
  - Writes in RUN/HALTED are dropped.
  - Memory contents are not cleared by reset.
- Fetched word:
  - HALT encoding is 32'hFFFF_FFFF.
  - Any `i_pc` ≥ `MEM_DEPTH`*4 fetches as HALT.
- PC+4 is computed as `i_pc`+4 modulo 2^MSB (wraps, no flag).
- Per-cycle decision in RUN with `i_step_en`=1, in priority order:
  1. `i_redirect`: `o_next_pc`=`i_redirect_pc`, `o_write_pc`=1. IF/ID loads NOP (32'h0) with valid=0 (flush). Redirect overrides `i_stall`.
  2. `i_stall`: `o_write_pc`=0; IF/ID holds its value.
  3. Fetched word is HALT: `o_write_pc`=0. IF/ID loads HALT, valid=1, `i_pc`+4. `o_halt`←1; next state HALTED.
  4. Otherwise: `o_next_pc`=`i_pc`+4, `o_write_pc`=1. IF/ID loads the fetched word, `i_pc`+4, valid=1.
- In RUN with `i_step_en`=0, or in IDLE/HALTED:
  - `o_write_pc`=0.
  - IF/ID holds in RUN.
  - IF/ID loads NOP/valid=0 in IDLE and HALTED, so the pipeline drains.
- `o_next_pc` when `o_write_pc`=0: `i_pc`+4 (don't-care for PC; fixed for determinism).

## Timing
- Reset values: state IDLE, `o_ifid_instr`=0, `o_ifid_pc4`=0, `o_ifid_valid`=0, `o_halt`=0, `o_state`=0.
- `o_write_pc`=0 whenever `i_rst`=1.
- `o_next_pc`/`o_write_pc` are combinational from `i_pc`, inputs and state, valid in the same cycle. The PC and IF/ID update on the same rising edge.
- Fetch latency: the word at address X appears on `o_ifid_instr` one edge after the cycle in which `i_pc`=X and the path was not stalled.
- Reset asserted mid-RUN: on the next edge all registers return to reset values; memory is kept.
- Load and start on the same edge: the write is performed (state is still IDLE), then the state becomes RUN.
- Redirect and HALT fetched in the same cycle: the redirect wins, and the HALT is discarded.

## Structure
- Shared package / header: HALT encoding, NOP encoding, state encodings (IDLE/RUN/HALTED), word size of 4.
- One sub-module, `instr_mem`: async-read, sync-write array with parameters `MSB`, `MEM_DEPTH`, `ADDR_W`.
- FSM, next-PC mux and IF/ID register live in `if_stage`.

## Test plan
- Reset then idle: `o_ifid_valid`=0, `o_write_pc`=0, `o_state`=0. Load 3 words plus HALT at addresses 0..3, pulse `i_start` → instructions appear on `o_ifid_instr` on successive edges with `o_ifid_pc4`=4,8,12. After the HALT edge, `o_halt`=1, `o_state`=2, and the PC freezes at 12.
- Stall at `i_pc`=8 for 2 cycles → `o_write_pc`=0 and IF/ID unchanged for 2 edges; the next edge loads word 2 with pc4=12.
- Redirect to 32'h40 while `i_stall`=1 → `o_next_pc`=32'h40, `o_write_pc`=1. Next edge: `o_ifid_instr`=0, `o_ifid_valid`=0.
- PC reaches `MEM_DEPTH`*4=1024 with no HALT in memory → treated as HALT; `o_halt`=1.
- `i_load_we` during RUN to address 0 with 32'hDEAD_BEEF → memory unchanged; re-fetching address 0 after a redirect returns the original word.
- `i_rst` pulsed while in RUN at `i_pc`=20 → next edge: state IDLE, all outputs at reset values, memory contents still readable after a restart.
